// File: rtl/p4_adder_pipe.sv
// Pipelined P4 adder: Kogge-Stone block-carry tree, carry-select block sums, valid/ready handshake.
// Optional signed-overflow output is enabled by defining P4_ADDER_OVF_EN.
module p4_adder_pipe #(
  parameter int NBIT           = 32,
  parameter int NBIT_PER_BLOCK = 4,
  parameter int PIPE_STAGES    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            cin,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NBIT-1:0] s,
  output logic            cout
`ifdef P4_ADDER_OVF_EN
  ,
  output logic            ovf
`endif
);

  localparam int NBLK = NBIT / NBIT_PER_BLOCK;
  localparam int LVLS = $clog2(NBLK);

  // Per-block generate/propagate, {g, p}; carry-in is applied only at the sum stage.
  function automatic logic [2*NBLK-1:0] block_gp(input logic [NBIT-1:0] x, input logic [NBIT-1:0] y);
    logic [NBLK-1:0] g;
    logic [NBLK-1:0] p;
    logic [NBIT-1:0] gb;
    logic [NBIT-1:0] pb;
    gb = x & y;
    pb = x ^ y;
    for (int i = 0; i < NBLK; i++) begin
      g[i] = 1'b0;
      p[i] = 1'b1;
      for (int j = 0; j < NBIT_PER_BLOCK; j++) begin
        g[i] = gb[i*NBIT_PER_BLOCK+j] | (pb[i*NBIT_PER_BLOCK+j] & g[i]);
        p[i] = p[i] & pb[i*NBIT_PER_BLOCK+j];
      end
    end
    return {g, p};
  endfunction

  // Applies prefix-tree levels lo+1..hi; level l combines blocks 2^(l-1) apart.
  function automatic logic [2*NBLK-1:0] ks_range(input logic [2*NBLK-1:0] gp, input int lo, input int hi);
    logic [NBLK-1:0] g;
    logic [NBLK-1:0] p;
    logic [NBLK-1:0] low;
    g = gp[2*NBLK-1:NBLK];
    p = gp[NBLK-1:0];
    for (int l = 1; l <= LVLS; l++) begin
      if (l > lo && l <= hi) begin
        low = (NBLK'(1) << (1 << (l - 1))) - NBLK'(1);
        g = g | (p & (g << (1 << (l - 1))));
        p = p & ((p << (1 << (l - 1))) | low);
      end
    end
    return {g, p};
  endfunction

  function automatic logic [NBIT-1:0] sum_sel(input logic [NBIT-1:0] x, input logic [NBIT-1:0] y,
                                              input logic [NBLK-1:0] cb);
    logic [NBIT-1:0]           r;
    logic [NBIT_PER_BLOCK-1:0] s0;
    logic [NBIT_PER_BLOCK-1:0] s1;
    for (int i = 0; i < NBLK; i++) begin
      s0 = x[i*NBIT_PER_BLOCK +: NBIT_PER_BLOCK] + y[i*NBIT_PER_BLOCK +: NBIT_PER_BLOCK];
      s1 = s0 + 1'b1;
      r[i*NBIT_PER_BLOCK +: NBIT_PER_BLOCK] = cb[i] ? s1 : s0;
    end
    return r;
  endfunction

  // Tree level reached by register stage j; the last pre-output register always holds full block carries.
  function automatic int cut_pos(input int j);
    if (j >= PIPE_STAGES - 2) return LVLS;
    return ((j + 1) * LVLS) / (PIPE_STAGES - 1);
  endfunction

  logic [NBIT-1:0]        in_b;
  logic                   in_c;
  logic [2*NBLK-1:0]      in_gp;
  logic [NBIT-1:0]        fin_a;
  logic [NBIT-1:0]        fin_b;
  logic                   fin_c;
  logic                   fin_v;
  logic [2*NBLK-1:0]      fin_gp;
  logic [PIPE_STAGES-1:0] v_all;
  logic [PIPE_STAGES-1:0] load;

  assign in_b  = sub ? ~b : b;
  assign in_c  = sub | cin;
  assign in_gp = block_gp(a, in_b);

  always_comb begin : ready_chain
    logic rdy;
    rdy  = out_ready;
    load = '0;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      load[k] = ~v_all[k] | rdy;
      rdy     = load[k];
    end
  end

  assign in_ready = load[0];
  assign v_all[PIPE_STAGES-1] = out_valid;

  generate
    if (PIPE_STAGES == 1) begin : g_direct
      assign fin_a  = a;
      assign fin_b  = in_b;
      assign fin_c  = in_c;
      assign fin_v  = in_valid;
      assign fin_gp = ks_range(in_gp, 0, LVLS);
    end else begin : g_pipe
      for (genvar gi = 0; gi < PIPE_STAGES - 1; gi++) begin : g_stage
        logic [NBIT-1:0]   a_reg;
        logic [NBIT-1:0]   b_reg;
        logic              c_reg;
        logic [2*NBLK-1:0] gp_reg;
        logic              v_reg;
        logic [NBIT-1:0]   a_next;
        logic [NBIT-1:0]   b_next;
        logic              c_next;
        logic [2*NBLK-1:0] gp_next;
        logic              v_next;

        if (gi == 0) begin : g_first
          assign a_next  = a;
          assign b_next  = in_b;
          assign c_next  = in_c;
          assign v_next  = in_valid;
          assign gp_next = ks_range(in_gp, 0, cut_pos(0));
        end else begin : g_mid
          assign a_next  = g_stage[gi-1].a_reg;
          assign b_next  = g_stage[gi-1].b_reg;
          assign c_next  = g_stage[gi-1].c_reg;
          assign v_next  = g_stage[gi-1].v_reg;
          assign gp_next = ks_range(g_stage[gi-1].gp_reg, cut_pos(gi - 1), cut_pos(gi));
        end

        assign v_all[gi] = v_reg;

        // Payload only moves with a valid op so bubbles never disturb held data.
        always_ff @(posedge clk) begin
          if (rst) begin
            v_reg  <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            c_reg  <= 1'b0;
            gp_reg <= '0;
          end else if (load[gi]) begin
            v_reg <= v_next;
            if (v_next) begin
              a_reg  <= a_next;
              b_reg  <= b_next;
              c_reg  <= c_next;
              gp_reg <= gp_next;
            end
          end
        end
      end

      assign fin_a  = g_stage[PIPE_STAGES-2].a_reg;
      assign fin_b  = g_stage[PIPE_STAGES-2].b_reg;
      assign fin_c  = g_stage[PIPE_STAGES-2].c_reg;
      assign fin_v  = g_stage[PIPE_STAGES-2].v_reg;
      assign fin_gp = g_stage[PIPE_STAGES-2].gp_reg;
    end
  endgenerate

  logic [NBLK:0]   blk_carry;
  logic [NBIT-1:0] sum_next;

  assign blk_carry = {fin_gp[2*NBLK-1:NBLK] | (fin_gp[NBLK-1:0] & {NBLK{fin_c}}), fin_c};
  assign sum_next  = sum_sel(fin_a, fin_b, blk_carry[NBLK-1:0]);

`ifdef P4_ADDER_OVF_EN
  logic ovf_next;
  assign ovf_next = (fin_a[NBIT-1] == fin_b[NBIT-1]) & (sum_next[NBIT-1] != fin_a[NBIT-1]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
`ifdef P4_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (load[PIPE_STAGES-1]) begin
      out_valid <= fin_v;
      if (fin_v) begin
        s    <= sum_next;
        cout <= blk_carry[NBLK];
`ifdef P4_ADDER_OVF_EN
        ovf  <= ovf_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_p4_adder_pipe.sv
// Bench for p4_adder_pipe: scoreboard on the default instance, latency/width sweep on side instances.
// Overflow checks are compiled in when P4_ADDER_OVF_EN is defined.
module tb_p4_adder_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, op_cin, op_sub, x_valid;
  logic [31:0] op_a, op_b;
  logic        in_ready, out_valid, cout;
  logic [31:0] s;
  logic [63:0] w_a, w_b;
  logic        d1_ir, d1_ov, d1_co, d4_ir, d4_ov, d4_co;
  logic [31:0] d1_s, d4_s;
  logic        e1_ir, e1_ov, e1_co, e4_ir, e4_ov, e4_co;
  logic [63:0] e1_s, e4_s;
`ifdef P4_ADDER_OVF_EN
  logic        ovf, d1_of, d4_of, e1_of, e4_of;
`endif

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  logic [33:0] sb[$];

  always #5 clk = ~clk;

  p4_adder_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(op_a), .b(op_b),
    .cin(op_cin), .sub(op_sub), .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout)
`ifdef P4_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  p4_adder_pipe #(.PIPE_STAGES(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(d1_ir), .a(op_a), .b(op_b),
    .cin(op_cin), .sub(op_sub), .out_valid(d1_ov), .out_ready(1'b1), .s(d1_s), .cout(d1_co)
`ifdef P4_ADDER_OVF_EN
    , .ovf(d1_of)
`endif
  );

  p4_adder_pipe #(.PIPE_STAGES(4)) d4 (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(d4_ir), .a(op_a), .b(op_b),
    .cin(op_cin), .sub(op_sub), .out_valid(d4_ov), .out_ready(1'b1), .s(d4_s), .cout(d4_co)
`ifdef P4_ADDER_OVF_EN
    , .ovf(d4_of)
`endif
  );

  p4_adder_pipe #(.NBIT(64), .NBIT_PER_BLOCK(8), .PIPE_STAGES(1)) e1 (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(e1_ir), .a(w_a), .b(w_b),
    .cin(1'b0), .sub(1'b0), .out_valid(e1_ov), .out_ready(1'b1), .s(e1_s), .cout(e1_co)
`ifdef P4_ADDER_OVF_EN
    , .ovf(e1_of)
`endif
  );

  p4_adder_pipe #(.NBIT(64), .NBIT_PER_BLOCK(8), .PIPE_STAGES(4)) e4 (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(e4_ir), .a(w_a), .b(w_b),
    .cin(1'b0), .sub(1'b0), .out_valid(e4_ov), .out_ready(1'b1), .s(e4_s), .cout(e4_co)
`ifdef P4_ADDER_OVF_EN
    , .ovf(e4_of)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, s}
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic m);
    logic [31:0] ye;
    logic [32:0] r;
    ye = m ? ~y : y;
    r  = {1'b0, x} + {1'b0, ye} + {32'd0, (m ? 1'b1 : c)};
    return {(x[31] == ye[31]) && (r[31] != x[31]), r};
  endfunction

  logic        stall_prev = 1'b0;
  logic [32:0] held;
  logic [33:0] exp_res;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_s", {31'd0, cout, s}, {31'd0, held});
        check("hold_valid", out_valid, 1);
      end
      check("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
      if (out_valid && out_ready) begin
        check("out_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_res = sb.pop_front();
          check("result", {31'd0, cout, s}, {31'd0, exp_res[32:0]});
`ifdef P4_ADDER_OVF_EN
          check("ovf", ovf, exp_res[33]);
`endif
          $display("out s=%h cout=%b expected s=%h cout=%b", s, cout, exp_res[31:0], exp_res[32]);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(op_a, op_b, op_cin, op_sub));
      stall_prev = out_valid && !out_ready;
      held       = {cout, s};
    end
  end

  // Drive one op from posedge+1, return at posedge+1 after it is accepted.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input logic ts);
    logic ok;
    op_a = ta; op_b = tb; op_cin = tc; op_sub = ts; in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
    end
    check("issue_accept", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic latency(input string tag, input int exp);
    int lat;
    lat = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    check(tag, lat, exp);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    check(tag, sb.size(), 0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc, l1, l4, le1, le4;
    logic acc;
    logic [32:0] r1, r4;
    logic [64:0] re1, re4;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x_valid = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0; w_a = '0; w_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // wrap-around add, latency 2
    issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    latency("t1_latency", 2);
    check("t1_s", s, 32'h0);
    // subtracts with and without borrow
    issue(32'd5, 32'd7, 1'b0, 1'b1);
    latency("t2a_latency", 2);
    check("t2a_s", s, 32'hFFFF_FFFE);
    check("t2a_cout", cout, 0);
    issue(32'd7, 32'd5, 1'b1, 1'b1);
    latency("t2b_latency", 2);
    check("t2b_s", s, 32'd2);
    check("t2b_cout", cout, 1);
    // signed overflow cases
    issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    issue(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    drain("t3_drain");

    // back-to-back random ops with random backpressure
    n = 0; cyc = 0;
    op_a = $urandom; op_b = $urandom; op_cin = 1'($urandom_range(0, 1)); op_sub = 1'($urandom_range(0, 1));
    in_valid = 1'b1; out_ready = 1'($urandom_range(0, 1));
    while (n < 32 && cyc < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        n++;
        op_a = $urandom; op_b = $urandom;
        op_cin = 1'($urandom_range(0, 1)); op_sub = 1'($urandom_range(0, 1));
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    check("t4_accepted", n, 32);
    drain("t4_drain");

    // reset with two ops stalled in flight
    out_ready = 1'b0;
    issue(32'd11, 32'd22, 1'b0, 1'b0);
    issue(32'd33, 32'd44, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_out_valid", out_valid, 0);
    check("t5_s", s, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    issue(32'd3, 32'd4, 1'b0, 1'b0);
    latency("t5_latency", 2);
    check("t5_new_s", s, 32'd7);
    drain("t5_drain");

    // parameter sweep on the side instances
    op_a = '0; op_b = '0; op_cin = 1'b1; op_sub = 1'b0;
    w_a = '1; w_b = '1;
    l1 = 0; l4 = 0; le1 = 0; le4 = 0;
    r1 = '0; r4 = '0; re1 = '0; re4 = '0;
    x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (d1_ov && l1 == 0) begin l1 = k; r1 = {d1_co, d1_s}; end
      if (d4_ov && l4 == 0) begin l4 = k; r4 = {d4_co, d4_s}; end
      if (e1_ov && le1 == 0) begin le1 = k; re1 = {e1_co, e1_s}; end
      if (e4_ov && le4 == 0) begin le4 = k; re4 = {e4_co, e4_s}; end
    end
    $display("sweep lat p1=%0d p4=%0d w64p1=%0d w64p4=%0d", l1, l4, le1, le4);
    check("t6_p1_latency", l1, 1);
    check("t6_p1_s", {31'd0, r1}, 64'h1);
    check("t6_p4_latency", l4, 4);
    check("t6_p4_s", {31'd0, r4}, 64'h1);
    check("t6_w64p1_latency", le1, 1);
    check("t6_w64p1_s", re1[63:0], 64'hFFFF_FFFF_FFFF_FFFE);
    check("t6_w64p1_cout", re1[64], 1);
    check("t6_w64p4_latency", le4, 4);
    check("t6_w64p4_s", re4[63:0], 64'hFFFF_FFFF_FFFF_FFFE);
    check("t6_w64p4_cout", re4[64], 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
